// File: rtl/crc_data_check.sv
// Receive-side CRC-16 checker: strips the trailing CRC word, moves EOP onto the
// last payload word, flags each packet pass/fail and keeps saturating statistics.
`timescale 1ns/1ps
module crc_data_check #(
   parameter int CNT_W = 16
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic             iRdSop,
   input  logic             iRdEop,
   input  logic             iRdVld,
   input  logic [31:0]      iRdData,
   input  logic             iDnFull,
   output logic             oFull,
   output logic             oSop,
   output logic             oEop,
   output logic             oVld,
   output logic [31:0]      oData,
   output logic             oCrcVld,
   output logic             oCrcErr,
   output logic [CNT_W-1:0] oPktOkCnt,
   output logic [CNT_W-1:0] oPktErrCnt
);

   typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

   state_t      state;
   logic [31:0] hold;
   logic        holdSop;
   logic [15:0] crc;
   logic        accept;

   // CRC-16/0x1021, one 32-bit word per step, MSB first.
   function automatic logic [15:0] crcStep(input logic [15:0] c, input logic [31:0] d);
      logic [15:0] r;
      logic        fb;
      r = c;
      for (int i = 31; i >= 0; i--) begin
         fb = r[15] ^ d[i];
         r  = {r[14:0], 1'b0};
         if (fb) r = r ^ 16'h1021;
      end
      return r;
   endfunction

   function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign oFull  = iDnFull;
   assign accept = iRdVld && !iDnFull;

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state      <= IDLE;
         hold       <= '0;
         holdSop    <= 1'b0;
         crc        <= 16'hFFFF;
         oVld       <= 1'b0;
         oSop       <= 1'b0;
         oEop       <= 1'b0;
         oData      <= '0;
         oCrcVld    <= 1'b0;
         oCrcErr    <= 1'b0;
         oPktOkCnt  <= '0;
         oPktErrCnt <= '0;
      end else begin
         oVld    <= 1'b0;
         oSop    <= 1'b0;
         oEop    <= 1'b0;
         oCrcVld <= 1'b0;
         oCrcErr <= 1'b0;
         if (accept) begin
            case (state)
               IDLE: begin
                  if (iRdSop) begin
                     if (iRdEop) begin
                        // SOP+EOP with nothing held: no room for a CRC, report and drop
                        oCrcVld    <= 1'b1;
                        oCrcErr    <= 1'b1;
                        oPktErrCnt <= satInc(oPktErrCnt);
                     end else begin
                        hold    <= iRdData;
                        holdSop <= 1'b1;
                        crc     <= 16'hFFFF;
                        state   <= HDR;
                     end
                  end
               end
               default: begin
                  oVld  <= 1'b1;
                  oSop  <= holdSop;
                  oData <= hold;
                  if (iRdSop) begin
                     // New header before the CRC word: close the held packet as failed
                     oEop       <= 1'b1;
                     oCrcVld    <= 1'b1;
                     oCrcErr    <= 1'b1;
                     oPktErrCnt <= satInc(oPktErrCnt);
                     if (iRdEop) begin
                        state <= IDLE;
                     end else begin
                        hold    <= iRdData;
                        holdSop <= 1'b1;
                        crc     <= 16'hFFFF;
                        state   <= HDR;
                     end
                  end else if (iRdEop) begin
                     oEop    <= 1'b1;
                     oCrcVld <= 1'b1;
                     oCrcErr <= (crc != iRdData[15:0]);
                     if (crc != iRdData[15:0]) oPktErrCnt <= satInc(oPktErrCnt);
                     else                      oPktOkCnt  <= satInc(oPktOkCnt);
                     state <= IDLE;
                  end else begin
                     hold    <= iRdData;
                     holdSop <= 1'b0;
                     crc     <= crcStep(crc, iRdData);
                     state   <= BODY;
                  end
               end
            endcase
         end
      end
   end

endmodule
